hub75_bcm_scanner: RTL and testbench

//  Parametrised HUB75 panel scanner: reads double-buffered frame RAM, drives 2-lane (top/bottom) RGB shift data,
//  row address, latch and OE using binary-code modulation (BCM), so OE time is weighted per bit-plane.

---
 rtl/hub75_pkg.sv | 29 ++
 rtl/hub75_bcm_timer.sv | 61 ++++++
 rtl/hub75_bcm_scanner.sv | 221 ++++++++++++++++++++++
 tb/tb_hub75_bcm_scanner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 BCM panel scanner.
package hub75_pkg;

  typedef enum logic [1:0] {StShift, StBlank, StLatch, StDisplay} state_e;

  // Channel offsets inside a {R,G,B} pixel word of 3*cb bits.
  function automatic int unsigned red_lsb(int unsigned cb);
    return 2 * cb;
  endfunction

  function automatic int unsigned green_lsb(int unsigned cb);
    return cb;
  endfunction

  function automatic int unsigned blue_lsb(int unsigned cb);
    return 0 * cb;
  endfunction

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return clog2_min1(max_val + 1);
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM display-slot timer: loads a plane weight and on-count, drives registered oe_n and flags
// the last cycle of the slot.
module hub75_bcm_timer #(
  parameter int unsigned DW = 7
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic [DW-1:0] weight_i,
  input  logic [DW-1:0] on_count_i,
  output logic          oe_n_o,
  output logic          done_o
);

  logic [DW-1:0] cnt_q, cnt_d, weight_q, weight_d, on_q, on_d;
  logic          active_q, active_d, oe_n_q, oe_n_d;

  assign done_o = active_q && (cnt_q == weight_q - DW'(1));
  assign oe_n_o = oe_n_q;

  always_comb begin
    cnt_d    = cnt_q;
    weight_d = weight_q;
    on_d     = on_q;
    active_d = active_q;
    oe_n_d   = oe_n_q;
    if (load_i) begin
      cnt_d    = '0;
      weight_d = weight_i;
      on_d     = on_count_i;
      active_d = 1'b1;
      oe_n_d   = (on_count_i == '0);
    end else if (active_q) begin
      if (done_o) begin
        active_d = 1'b0;
        oe_n_d   = 1'b1;
      end else begin
        cnt_d  = cnt_q + DW'(1);
        // cnt_d is the index of the next display cycle
        oe_n_d = !(cnt_d < on_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      weight_q <= '0;
      on_q     <= '0;
      active_q <= 1'b0;
      oe_n_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      on_q     <= on_d;
      active_q <= active_d;
      oe_n_q   <= oe_n_d;
    end
  end

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 BCM scanner: shifts double-buffered frame RAM to a 2-lane panel with bit-plane weighted OE.
// Optional global dimming is enabled by defining HUB75_BRIGHTNESS_EN.
module hub75_bcm_scanner
  import hub75_pkg::*;
#(
  parameter int unsigned PANEL_WIDTH = 64,
  parameter int unsigned SCAN_ROWS   = 16,
  parameter int unsigned COLOUR_BITS = 4,
  parameter int unsigned BASE_OE     = 8,
  parameter int unsigned DEADTIME    = 2
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  output logic [clog2_min1(SCAN_ROWS)+clog2_min1(PANEL_WIDTH):0] rd_addr,
  input  logic [3*COLOUR_BITS-1:0]                                rd_data_top,
  input  logic [3*COLOUR_BITS-1:0]                                rd_data_bottom,
  input  logic                                                    swap_req,
  output logic                                                    swap_ack,
  output logic                                                    front_buf,
  output logic                                                    frame_start,
  input  logic [7:0]                                              brightness,
  output logic [1:0]                                              hub75_red,
  output logic [1:0]                                              hub75_green,
  output logic [1:0]                                              hub75_blue,
  output logic                                                    hub75_clk,
  output logic                                                    hub75_latch,
  output logic                                                    hub75_oe,
  output logic [clog2_min1(SCAN_ROWS)-1:0]                        hub75_addr
);

  localparam int unsigned CW  = clog2_min1(PANEL_WIDTH);
  localparam int unsigned RW  = clog2_min1(SCAN_ROWS);
  localparam int unsigned PW  = clog2_min1(COLOUR_BITS);
  localparam int unsigned DW  = cnt_width(BASE_OE << (COLOUR_BITS - 1));
  localparam int unsigned DTW = cnt_width(DEADTIME);
  localparam int unsigned AW  = 1 + RW + CW;

  state_e           state_q, state_d;
  logic [RW-1:0]    row_q, row_d, addr_q, addr_d;
  logic [PW-1:0]    plane_q, plane_d;
  logic [CW-1:0]    col_q, col_d;
  logic [DTW-1:0]   dead_q, dead_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [1:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             phase_q, phase_d, hclk_q, hclk_d, latch_q, latch_d;
  logic             front_buf_q, front_buf_d, swap_ack_q, swap_ack_d, fstart_q, fstart_d;
  logic             timer_load, timer_done, timer_oe_n;
  logic [DW-1:0]    weight, on_count;

  logic [COLOUR_BITS-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;
  assign top_r = rd_data_top[red_lsb(COLOUR_BITS) +: COLOUR_BITS];
  assign top_g = rd_data_top[green_lsb(COLOUR_BITS) +: COLOUR_BITS];
  assign top_b = rd_data_top[blue_lsb(COLOUR_BITS) +: COLOUR_BITS];
  assign bot_r = rd_data_bottom[red_lsb(COLOUR_BITS) +: COLOUR_BITS];
  assign bot_g = rd_data_bottom[green_lsb(COLOUR_BITS) +: COLOUR_BITS];
  assign bot_b = rd_data_bottom[blue_lsb(COLOUR_BITS) +: COLOUR_BITS];

  assign weight = DW'(BASE_OE) << plane_q;

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]    bright_q, bright_d;
  logic [DW+8:0] prod;
  assign prod     = {9'd0, weight} * {{DW{1'b0}}, ({1'b0, bright_q} + 9'd1)};
  assign on_count = DW'(prod >> 8);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign on_count          = weight;
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    plane_d     = plane_q;
    col_d       = col_q;
    phase_d     = phase_q;
    dead_d      = dead_q;
    addr_d      = addr_q;
    rd_addr_d   = rd_addr_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    front_buf_d = front_buf_q;
    hclk_d      = 1'b0;
    latch_d     = 1'b0;
    swap_ack_d  = 1'b0;
    fstart_d    = 1'b0;
    timer_load  = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
    bright_d    = bright_q;
`endif
    unique case (state_q)
      StShift: begin
        // Outputs trail the phase by one cycle so data settles while hub75_clk is low.
        if (!phase_q) begin
          red_d     = {bot_r[plane_q], top_r[plane_q]};
          green_d   = {bot_g[plane_q], top_g[plane_q]};
          blue_d    = {bot_b[plane_q], top_b[plane_q]};
          rd_addr_d = {front_buf_q, row_q, col_q + 1'b1};
          phase_d   = 1'b1;
        end else begin
          hclk_d  = 1'b1;
          phase_d = 1'b0;
          col_d   = col_q + 1'b1;
          if (col_q == CW'(PANEL_WIDTH - 1)) begin
            state_d = StBlank;
            dead_d  = '0;
            addr_d  = row_q;
          end
        end
      end
      StBlank: begin
        if (dead_q == DTW'(DEADTIME - 1)) begin
          state_d = StLatch;
          latch_d = 1'b1;
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      StLatch: begin
        timer_load = 1'b1;
        state_d    = StDisplay;
      end
      StDisplay: begin
        if (timer_done) begin
          state_d = StShift;
          col_d   = '0;
          phase_d = 1'b0;
          if (plane_q == PW'(COLOUR_BITS - 1)) begin
            plane_d = '0;
            row_d   = (row_q == RW'(SCAN_ROWS - 1)) ? '0 : row_q + 1'b1;
            if (row_q == RW'(SCAN_ROWS - 1)) begin
              fstart_d = 1'b1;
`ifdef HUB75_BRIGHTNESS_EN
              bright_d = brightness;
`endif
              if (swap_req) begin
                front_buf_d = ~front_buf_q;
                swap_ack_d  = 1'b1;
              end
            end
          end else begin
            plane_d = plane_q + 1'b1;
          end
          // Pixel 0 of the next plane is fetched from the post-flip buffer.
          rd_addr_d = {front_buf_d, row_d, {CW{1'b0}}};
        end
      end
      default: state_d = StShift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StShift;
      row_q       <= '0;
      plane_q     <= '0;
      col_q       <= '0;
      phase_q     <= 1'b0;
      dead_q      <= '0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hclk_q      <= 1'b0;
      latch_q     <= 1'b0;
      front_buf_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      fstart_q    <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q    <= brightness;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      col_q       <= col_d;
      phase_q     <= phase_d;
      dead_q      <= dead_d;
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hclk_q      <= hclk_d;
      latch_q     <= latch_d;
      front_buf_q <= front_buf_d;
      swap_ack_q  <= swap_ack_d;
      fstart_q    <= fstart_d;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q    <= bright_d;
`endif
    end
  end

  hub75_bcm_timer #(
    .DW(DW)
  ) u_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (timer_load),
    .weight_i   (weight),
    .on_count_i (on_count),
    .oe_n_o     (timer_oe_n),
    .done_o     (timer_done)
  );

  assign rd_addr     = rd_addr_q;
  assign hub75_red   = red_q;
  assign hub75_green = green_q;
  assign hub75_blue  = blue_q;
  assign hub75_clk   = hclk_q;
  assign hub75_latch = latch_q;
  assign hub75_oe    = timer_oe_n;
  assign hub75_addr  = addr_q;
  assign front_buf   = front_buf_q;
  assign swap_ack    = swap_ack_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner at default parameters (64 wide, 16 rows, 4 planes).
module tb_hub75_bcm_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] rd_addr;
  logic [11:0] rd_data_top, rd_data_bottom;
  logic        swap_req, swap_ack, front_buf, frame_start;
  logic [7:0]  brightness;
  logic [1:0]  hub75_red, hub75_green, hub75_blue;
  logic        hub75_clk, hub75_latch, hub75_oe;
  logic [3:0]  hub75_addr;

  always #5 clk = ~clk;

  hub75_bcm_scanner dut (
    .clk            (clk),
    .reset          (reset),
    .rd_addr        (rd_addr),
    .rd_data_top    (rd_data_top),
    .rd_data_bottom (rd_data_bottom),
    .swap_req       (swap_req),
    .swap_ack       (swap_ack),
    .front_buf      (front_buf),
    .frame_start    (frame_start),
    .brightness     (brightness),
    .hub75_red      (hub75_red),
    .hub75_green    (hub75_green),
    .hub75_blue     (hub75_blue),
    .hub75_clk      (hub75_clk),
    .hub75_latch    (hub75_latch),
    .hub75_oe       (hub75_oe),
    .hub75_addr     (hub75_addr)
  );

  // RAM model: mode 0 all 0xFFF; mode 1 only top pixel column 5 has R=4'b1010.
  int mode = 0;
  assign rd_data_top    = (mode == 0) ? 12'hFFF : ((rd_addr[5:0] == 6'd5) ? 12'hA00 : 12'h000);
  assign rd_data_bottom = (mode == 0) ? 12'hFFF : 12'h000;

  typedef struct {
    int          rises;
    logic [63:0] vec;
    bit          other;
    int          row;
    int          since;
  } lat_t;

  typedef struct {
    int rises;
    int oe_low;
    int row;
  } vec_t;

  lat_t lat_q[$];
  int   oe_q[$];
  int   epoch = 0, seen_epoch = -1;
  int   rise_cnt, oe_cnt, since_addr, latch_run, ack_cnt, oe_bad, addr_bad, latch_bad, buf_err;
  logic [63:0] shift_vec;
  bit   other, after_latch;
  logic prev_clk, prev_latch;
  logic [3:0] prev_addr;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      lat_q.delete();
      oe_q.delete();
      rise_cnt = 0; oe_cnt = 0; since_addr = 0; latch_run = 0; ack_cnt = 0;
      oe_bad = 0; addr_bad = 0; latch_bad = 0; buf_err = 0;
      shift_vec = '0; other = 1'b0; after_latch = 1'b0;
    end else if (!reset) begin
      if (hub75_clk && !prev_clk) begin
        if (after_latch) begin
          oe_q.push_back(oe_cnt);
          after_latch = 1'b0;
        end
        if (rise_cnt < 64) shift_vec[rise_cnt] = hub75_red[0];
        other = other | hub75_red[1] | (|hub75_green) | (|hub75_blue);
        rise_cnt++;
        if (rd_addr[10] != front_buf) buf_err++;
      end
      if (!hub75_oe) begin
        if (after_latch) oe_cnt++;
        else oe_bad++;
      end
      if (hub75_addr != prev_addr) begin
        if (!hub75_oe) addr_bad++;
        since_addr = 0;
      end else begin
        since_addr++;
      end
      if (hub75_latch) begin
        latch_run++;
        if (!prev_latch) begin
          lat_q.push_back('{rise_cnt, shift_vec, other, int'(hub75_addr), since_addr});
          rise_cnt = 0; shift_vec = '0; other = 1'b0; after_latch = 1'b1; oe_cnt = 0;
        end
      end else if (prev_latch) begin
        if (latch_run != 1) latch_bad++;
        latch_run = 0;
      end
      if (swap_ack) ack_cnt++;
    end
    prev_clk   = hub75_clk;
    prev_latch = hub75_latch;
    prev_addr  = hub75_addr;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int budget);
    total++;
    bad++;
    $display("FAIL %s: no event within %0d cycles", name, budget);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    epoch++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_recs(input int n, input int budget, input string name);
    int c = 0;
    while ((lat_q.size() < n || oe_q.size() < n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) timeout(name, budget);
  endtask

  task automatic wait_display_row(input int row, input int budget, input string name);
    int c = 0;
    @(negedge clk);
    while (!(hub75_addr == 4'(row) && !hub75_oe) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) timeout(name, budget);
  endtask

  vec_t tbl1[8];
  int   exp_oe127[4], exp_oe0[4];

  initial begin
    tbl1[0] = '{64, 8, 0};  tbl1[1] = '{64, 16, 0};
    tbl1[2] = '{64, 32, 0}; tbl1[3] = '{64, 64, 0};
    tbl1[4] = '{64, 8, 1};  tbl1[5] = '{64, 16, 1};
    tbl1[6] = '{64, 32, 1}; tbl1[7] = '{64, 64, 1};
`ifdef HUB75_BRIGHTNESS_EN
    exp_oe127 = '{4, 8, 16, 32};
    exp_oe0   = '{0, 0, 0, 0};
`else
    exp_oe127 = '{8, 16, 32, 64};
    exp_oe0   = '{8, 16, 32, 64};
`endif

    reset = 1'b1; swap_req = 1'b0; brightness = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    check("reset_oe", hub75_oe, 1);
    check("reset_latch", hub75_latch, 0);
    check("reset_hclk", hub75_clk, 0);
    check("reset_addr", hub75_addr, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_colour", {hub75_red, hub75_green, hub75_blue}, 0);
    check("reset_flags", {front_buf, swap_ack, frame_start}, 0);

    // All-ones image: shift count, latch, plane weights, row order.
    mode = 0;
    apply_reset();
    wait_recs(8, 3000, "t1_wait");
    for (int i = 0; i < 8; i++) begin
      if (i < lat_q.size() && i < oe_q.size()) begin
        check($sformatf("t1_rises[%0d]", i), lat_q[i].rises, tbl1[i].rises);
        check($sformatf("t1_oe_low[%0d]", i), oe_q[i], tbl1[i].oe_low);
        check($sformatf("t1_row[%0d]", i), lat_q[i].row, tbl1[i].row);
      end
    end
    if (lat_q.size() > 0) check("t1_vec", lat_q[0].vec, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_latch_width", latch_bad, 0);
    check("t1_oe_outside", oe_bad, 0);

    // Single pixel red bit pattern per plane.
    mode = 1;
    apply_reset();
    wait_recs(4, 2000, "t2_wait");
    for (int i = 0; i < 4; i++) begin
      if (i < lat_q.size()) begin
        check($sformatf("t2_red_top[%0d]", i), lat_q[i].vec, (i % 2 == 1) ? 64'h20 : 64'h0);
        check($sformatf("t2_other[%0d]", i), lat_q[i].other, 0);
      end
    end

    // Brightness scaling.
    mode = 0;
    brightness = 8'd127;
    apply_reset();
    wait_recs(4, 2000, "t5_wait127");
    for (int i = 0; i < 4; i++)
      if (i < oe_q.size()) check($sformatf("t5_oe127[%0d]", i), oe_q[i], exp_oe127[i]);
    brightness = 8'd0;
    apply_reset();
    wait_recs(4, 2000, "t5_wait0");
    for (int i = 0; i < 4; i++)
      if (i < oe_q.size()) check($sformatf("t5_oe0[%0d]", i), oe_q[i], exp_oe0[i]);
    check("t5_oe_outside", oe_bad, 0);

    // Swap request mid-frame, frame wrap, row address discipline.
    brightness = 8'd255;
    apply_reset();
    repeat (3000) @(negedge clk);
    check("t3_buf_before", front_buf, 0);
    check("t3_ack_before", ack_cnt, 0);
    swap_req = 1'b1;
    begin
      int c = 0;
      @(negedge clk);
      while (!frame_start && c < 12000) begin
        @(negedge clk);
        c++;
      end
      if (c >= 12000) timeout("t3_frame_start", 12000);
    end
    check("t3_buf_after", front_buf, 1);
    check("t3_ack_pulse", swap_ack, 1);
    check("t3_rd_addr_msb", rd_addr[10], 1);
    check("t4_latches_per_frame", lat_q.size(), 64);
    begin
      int row_err = 0, dt_err = 0;
      for (int i = 0; i < lat_q.size(); i++) begin
        if (lat_q[i].row != i / 4) row_err++;
        if (lat_q[i].since < 2) dt_err++;
      end
      check("t4_row_order", row_err, 0);
      check("t4_deadtime", dt_err, 0);
    end
    @(negedge clk);
    check("t3_ack_width", swap_ack, 0);
    wait_recs(65, 2000, "t4_wrap_wait");
    if (lat_q.size() > 64) check("t4_row_wrap", lat_q[64].row, 0);

    // Reset during row 7 display with buffer 1 showing.
    wait_display_row(7, 8000, "t6_wait_row7");
    check("t3_one_flip_held", ack_cnt, 1);
    check("t4_addr_only_blanked", addr_bad, 0);
    check("t3_rd_buf_track", buf_err, 0);
    check("t4_latch_width", latch_bad, 0);
    swap_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_oe", hub75_oe, 1);
    check("t6_latch", hub75_latch, 0);
    check("t6_addr", hub75_addr, 0);
    check("t6_front_buf", front_buf, 0);
    check("t6_rd_addr", rd_addr, 0);
    epoch++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_recs(1, 1000, "t6_restart");
    if (lat_q.size() > 0) begin
      check("t6_restart_row", lat_q[0].row, 0);
      check("t6_restart_rises", lat_q[0].rises, 64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
